// File: rtl/plca_pkg.sv
// Shared types and constants for the PLCA wait_beacon_timer controller slice.
package plca_pkg;

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        DRAW     = 3'd1,
        WAIT     = 3'd2,
        EXPIRED  = 3'd3,
        SYNCED   = 3'd4
    } ctrl_state_e;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1, right-shifting form.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    localparam int BT_CNT_W = 9;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
    endfunction

endpackage

// File: rtl/plca_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the random source for timer draws.
module plca_lfsr16
    import plca_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    // NOTE: sequential state uses non-blocking assignments and an async reset branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/plca_wait_beacon_ctrl.sv
// wait_beacon_timer sequencer for a PLCA follower: random draw, BT countdown,
// BEACON freeze and expiry hand-off to the coordinator role.
module plca_wait_beacon_ctrl
    import plca_pkg::*;
#(
    parameter int          WAIT_MIN  = 40,
    parameter int          WAIT_MAX  = 295,
    parameter int          BT_CLKS   = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       plca_en,
    input  logic       restart,
    input  logic       beacon_det,
    output logic       wait_beacon_timer_done,
    output logic       wait_beacon_timer_not_done,
    output logic       coordinator_req,
    output logic [8:0] timer_remaining,
    output logic [8:0] draw_value,
    output logic [2:0] ctrl_state
);

    localparam int                RANGE      = WAIT_MAX - WAIT_MIN + 1;
    localparam int                PRE_W      = (BT_CLKS > 1) ? $clog2(BT_CLKS) : 1;
    localparam logic [7:0]        RANGE_MASK = 8'(RANGE - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(BT_CLKS - 1);

    ctrl_state_e          state;
    logic [PRE_W-1:0]     prescaler;
    logic [15:0]          lfsr;
    logic [BT_CNT_W-1:0]  duration;
    logic                 bt_tick;
    logic                 load_draw;
    logic                 unused_lfsr_hi;

    plca_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr)
    );

    // Only the low byte feeds the draw; RANGE never exceeds 256.
    assign unused_lfsr_hi = ^lfsr[15:8];

    assign duration   = BT_CNT_W'(WAIT_MIN) + {1'b0, lfsr[7:0] & RANGE_MASK};
    assign bt_tick    = (prescaler == PRE_LAST);
    assign ctrl_state = state;

    // A BEACON in WAIT/EXPIRED outranks restart; elsewhere restart stands alone.
    always_comb begin
        load_draw = 1'b0;
        case (state)
            DISABLED:      load_draw = 1'b1;
            WAIT, EXPIRED: load_draw = restart && !beacon_det;
            SYNCED:        load_draw = restart;
            default:       load_draw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= DISABLED;
            prescaler                  <= '0;
            timer_remaining            <= '0;
            draw_value                 <= '0;
            wait_beacon_timer_done     <= 1'b0;
            wait_beacon_timer_not_done <= 1'b0;
            coordinator_req            <= 1'b0;
        end else begin
            coordinator_req <= 1'b0;
            if (!plca_en) begin
                state                      <= DISABLED;
                prescaler                  <= '0;
                timer_remaining            <= '0;
                draw_value                 <= '0;
                wait_beacon_timer_done     <= 1'b0;
                wait_beacon_timer_not_done <= 1'b0;
            end else if (load_draw) begin
                state                      <= DRAW;
                timer_remaining            <= duration;
                draw_value                 <= duration;
                prescaler                  <= '0;
                wait_beacon_timer_done     <= 1'b0;
                wait_beacon_timer_not_done <= 1'b0;
            end else begin
                case (state)
                    DRAW: begin
                        state                      <= WAIT;
                        prescaler                  <= '0;
                        wait_beacon_timer_not_done <= 1'b1;
                    end
                    WAIT: begin
                        if (beacon_det) begin
                            // Freeze: the count stays at its value in the detection cycle.
                            state                      <= SYNCED;
                            wait_beacon_timer_not_done <= 1'b0;
                        end else if (bt_tick) begin
                            prescaler       <= '0;
                            timer_remaining <= timer_remaining - 9'd1;
                            if (timer_remaining == 9'd1) begin
                                state                      <= EXPIRED;
                                wait_beacon_timer_not_done <= 1'b0;
                                wait_beacon_timer_done     <= 1'b1;
                                coordinator_req            <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
                    EXPIRED: begin
                        if (beacon_det) begin
                            state                  <= SYNCED;
                            wait_beacon_timer_done <= 1'b0;
                        end
                    end
                    DISABLED, SYNCED: begin
                    end
                    default: state <= DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plca_wait_beacon_ctrl.sv
// Directed vector table plus multi-cycle sequences for plca_wait_beacon_ctrl.
`timescale 1ns/1ps
module tb_plca_wait_beacon_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: fixed 40 BT draw. Instance B: default parameters.
    logic       a_reset, a_en, a_restart, a_beacon;
    logic       a_done, a_nd, a_creq;
    logic [8:0] a_rem, a_draw;
    logic [2:0] a_st;

    logic       b_reset, b_en, b_restart, b_beacon;
    logic       b_done, b_nd, b_creq;
    logic [8:0] b_rem, b_draw;
    logic [2:0] b_st;

    plca_wait_beacon_ctrl #(
        .WAIT_MIN (40),
        .WAIT_MAX (40),
        .BT_CLKS  (10)
    ) u_a (
        .clk                        (clk),
        .reset                      (a_reset),
        .plca_en                    (a_en),
        .restart                    (a_restart),
        .beacon_det                 (a_beacon),
        .wait_beacon_timer_done     (a_done),
        .wait_beacon_timer_not_done (a_nd),
        .coordinator_req            (a_creq),
        .timer_remaining            (a_rem),
        .draw_value                 (a_draw),
        .ctrl_state                 (a_st)
    );

    plca_wait_beacon_ctrl u_b (
        .clk                        (clk),
        .reset                      (b_reset),
        .plca_en                    (b_en),
        .restart                    (b_restart),
        .beacon_det                 (b_beacon),
        .wait_beacon_timer_done     (b_done),
        .wait_beacon_timer_not_done (b_nd),
        .coordinator_req            (b_creq),
        .timer_remaining            (b_rem),
        .draw_value                 (b_draw),
        .ctrl_state                 (b_st)
    );

    // Reference LFSR for instance B, straight from the polynomial.
    function automatic logic [15:0] ref_lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ 16'hB400) : (cur >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge b_reset) begin
        if (b_reset) m_lfsr <= 16'hACE1;
        else         m_lfsr <= ref_lfsr_step(m_lfsr);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic a_step(input logic en, input logic rs, input logic bc);
        a_en = en; a_restart = rs; a_beacon = bc;
        @(posedge clk); #1;
        a_restart = 1'b0; a_beacon = 1'b0;
    endtask

    task automatic b_step(input logic rs);
        b_restart = rs;
        @(posedge clk); #1;
        b_restart = 1'b0;
    endtask

    typedef struct {
        logic       en, restart, beacon;
        int         gap;
        logic [2:0] st;
        logic       done, nd, creq;
        logic [8:0] rem, draw;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    function automatic vec_t mkv(logic en, logic rs, logic bc, int gap, logic [2:0] st,
                                 logic d, logic nd, logic cr, logic [8:0] rem, logic [8:0] drw);
        vec_t v;
        v.en = en; v.restart = rs; v.beacon = bc; v.gap = gap;
        v.st = st; v.done = d; v.nd = nd; v.creq = cr; v.rem = rem; v.draw = drw;
        return v;
    endfunction

    int         cnt;
    logic       seen_bad;
    logic [8:0] exp_draw;
    bit         seen[256];
    int         distinct;
    int         out_of_range;

    initial begin
        //                 en rs bc gap  st    d  nd cr rem drw
        vecs[0]  = mkv(1'b0, 0, 0,   0, 3'd0, 0, 0, 0,  0,  0);  // reset state
        vecs[1]  = mkv(1'b1, 0, 0,   0, 3'd1, 0, 0, 0, 40, 40);  // enable -> DRAW
        vecs[2]  = mkv(1'b1, 0, 0,   0, 3'd2, 0, 1, 0, 40, 40);  // WAIT cycle 0
        vecs[3]  = mkv(1'b1, 0, 0,   8, 3'd2, 0, 1, 0, 40, 40);  // WAIT cycle 9, tick pending
        vecs[4]  = mkv(1'b1, 0, 0,   0, 3'd2, 0, 1, 0, 39, 40);  // first BT elapsed
        vecs[5]  = mkv(1'b1, 0, 1,   0, 3'd4, 0, 0, 0, 39, 40);  // beacon -> SYNCED
        vecs[6]  = mkv(1'b1, 0, 1,   4, 3'd4, 0, 0, 0, 39, 40);  // beacon ignored in SYNCED
        vecs[7]  = mkv(1'b1, 1, 0,   0, 3'd1, 0, 0, 0, 40, 40);  // restart from SYNCED
        vecs[8]  = mkv(1'b1, 0, 0, 399, 3'd2, 0, 1, 0,  1, 40);  // WAIT cycle 399
        vecs[9]  = mkv(1'b1, 0, 0,   0, 3'd3, 1, 0, 1,  0, 40);  // expiry
        vecs[10] = mkv(1'b1, 0, 0,   0, 3'd3, 1, 0, 0,  0, 40);  // req pulse over
        vecs[11] = mkv(1'b1, 1, 0,   0, 3'd1, 0, 0, 0, 40, 40);  // restart from EXPIRED
        vecs[12] = mkv(1'b1, 0, 0,   0, 3'd2, 0, 1, 0, 40, 40);
        vecs[13] = mkv(1'b0, 0, 0,   0, 3'd0, 0, 0, 0,  0,  0);  // disable mid-WAIT
        vecs[14] = mkv(1'b0, 1, 0,   2, 3'd0, 0, 0, 0,  0,  0);  // restart ignored
        vecs[15] = mkv(1'b1, 0, 0,   0, 3'd1, 0, 0, 0, 40, 40);  // fresh DRAW
        vecs[16] = mkv(1'b0, 0, 0,   0, 3'd0, 0, 0, 0,  0,  0);  // disable mid-DRAW
        vecs[17] = mkv(1'b1, 0, 0,   0, 3'd1, 0, 0, 0, 40, 40);
        vecs[18] = mkv(1'b1, 0, 0,  50, 3'd2, 0, 1, 0, 35, 40);  // WAIT cycle 50
        vecs[19] = mkv(1'b1, 1, 0,   0, 3'd1, 0, 0, 0, 40, 40);  // restart mid-WAIT
        vecs[20] = mkv(1'b1, 0, 0,   0, 3'd2, 0, 1, 0, 40, 40);
        vecs[21] = mkv(1'b1, 1, 1,   0, 3'd4, 0, 0, 0, 40, 40);  // beacon beats restart

        a_reset = 1'b1; a_en = 1'b0; a_restart = 1'b0; a_beacon = 1'b0;
        b_reset = 1'b1; b_en = 1'b0; b_restart = 1'b0; b_beacon = 1'b0;
        #22;
        a_reset = 1'b0;
        b_reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            a_step(vecs[i].en, vecs[i].restart, vecs[i].beacon);
            for (int g = 0; g < vecs[i].gap; g++) a_step(vecs[i].en, 1'b0, 1'b0);
            check($sformatf("vec%0d", i),
                  {8'h0, a_st, a_done, a_nd, a_creq, a_rem, a_draw},
                  {8'h0, vecs[i].st, vecs[i].done, vecs[i].nd, vecs[i].creq,
                   vecs[i].rem, vecs[i].draw});
        end

        // Full count: done exactly 400 cycles after WAIT entry, one-cycle request.
        a_step(1'b1, 1'b1, 1'b0);
        check("seq1_draw", {a_st, a_draw}, {3'd1, 9'd40});
        a_step(1'b1, 1'b0, 1'b0);
        cnt = 0;
        while (!a_done && cnt < 1000) begin
            a_step(1'b1, 1'b0, 1'b0);
            cnt++;
        end
        check("seq1_expiry_cycles", cnt, 400);
        check("seq1_req_first", a_creq, 1'b1);
        a_step(1'b1, 1'b0, 1'b0);
        check("seq1_req_second", {a_creq, a_done}, 2'b01);

        // Beacon at WAIT cycle 200 freezes the count at 20.
        a_step(1'b1, 1'b1, 1'b0);
        a_step(1'b1, 1'b0, 1'b0);
        repeat (200) a_step(1'b1, 1'b0, 1'b0);
        a_step(1'b1, 1'b0, 1'b1);
        check("seq2_synced", {a_st, a_nd, a_done, a_rem}, {3'd4, 1'b0, 1'b0, 9'd20});
        seen_bad = 1'b0;
        repeat (500) begin
            a_step(1'b1, 1'b0, 1'b0);
            if (a_creq || a_done) seen_bad = 1'b1;
        end
        check("seq2_no_req", seen_bad, 1'b0);

        // Beacon in the cycle of the final tick wins over expiry.
        a_step(1'b1, 1'b1, 1'b0);
        a_step(1'b1, 1'b0, 1'b0);
        repeat (399) a_step(1'b1, 1'b0, 1'b0);
        check("seq3_last_bt", {a_st, a_rem}, {3'd2, 9'd1});
        a_step(1'b1, 1'b0, 1'b1);
        check("seq3_synced", {a_st, a_done, a_creq}, {3'd4, 1'b0, 1'b0});
        seen_bad = 1'b0;
        repeat (20) begin
            a_step(1'b1, 1'b0, 1'b0);
            if (a_creq || a_done) seen_bad = 1'b1;
        end
        check("seq3_no_req", seen_bad, 1'b0);

        // Default parameters: 1000 redraws with random spacing.
        b_en = 1'b1;
        exp_draw = 9'd40 + {1'b0, m_lfsr[7:0]};
        b_step(1'b0);
        check("b_first_draw", {b_st, b_draw}, {3'd1, exp_draw});
        b_step(1'b0);
        out_of_range = 0;
        for (int k = 0; k < 1000; k++) begin
            exp_draw = 9'd40 + {1'b0, m_lfsr[7:0]};
            b_step(1'b1);
            check($sformatf("b_draw%0d", k), b_draw, exp_draw);
            if (b_draw < 9'd40 || b_draw > 9'd295) out_of_range++;
            else seen[b_draw - 9'd40] = 1'b1;
            repeat ($urandom_range(1, 20)) b_step(1'b0);
        end
        distinct = 0;
        for (int v = 0; v < 256; v++) if (seen[v]) distinct++;
        check("b_range", out_of_range, 0);
        check("b_distinct_ge_200", (distinct >= 200), 1);

        for (int k = 0; k < 3; k++) begin
            b_step(1'b1);
            exp_draw = b_draw;
            b_step(1'b0);
            cnt = 0;
            while (!b_done && cnt < 4000) begin
                b_step(1'b0);
                cnt++;
            end
            check($sformatf("b_expiry%0d", k), cnt, exp_draw * 10);
        end

        // Async reset mid-WAIT, asserted and released between clock edges.
        b_step(1'b1);
        repeat (50) b_step(1'b0);
        check("b_pre_reset_wait", b_st, 3'd2);
        #1 b_reset = 1'b1;
        #1;
        check("b_async_reset", {b_st, b_done, b_nd, b_creq, b_rem, b_draw}, 24'h0);
        #1 b_reset = 1'b0;
        @(posedge clk); #1;
        check("b_seed_reload_draw", {b_st, b_draw}, {3'd1, 9'd265});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
